// File: rtl/vend_sequencer.sv
`timescale 1ns/1ps
// vend_sequencer
// Sequencing controller for the Cola Next vending datapath. It accumulates
// coin credit, takes a 4-way product selection, runs a request/ack dispense
// handshake with the product motor, and pays change or refunds as a train of
// Rs5 pulses.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   COIN          00 none, 01 Rs5, 10 Rs10, 11 invalid (sampled every cycle)
//   SEL_VALID     one-cycle product-select strobe
//   SEL           product index, valid with SEL_VALID
//   CANCEL        one-cycle refund request
//   DISP_ACK      motor done (level, held until DISP_REQ drops)
//   DISP_REQ      dispense request to motor
//   DISP_SEL      product index, stable while DISP_REQ=1
//   CHANGE_PULSE  one Rs5 coin returned per high cycle
//   COIN_REJ      previous cycle's coin was rejected
//   FAULT         sticky motor-timeout flag
//   CREDIT        current credit in Rs
//   BUSY          high in DISPENSE or PAYOUT
module vend_sequencer #(
  parameter int unsigned PRICE0      = 15,
  parameter int unsigned PRICE1      = 20,
  parameter int unsigned PRICE2      = 25,
  parameter int unsigned PRICE3      = 30,
  parameter int unsigned MAX_CREDIT  = 50,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] COIN,
  input  logic       SEL_VALID,
  input  logic [1:0] SEL,
  input  logic       CANCEL,
  input  logic       DISP_ACK,
  output logic       DISP_REQ,
  output logic [1:0] DISP_SEL,
  output logic       CHANGE_PULSE,
  output logic       COIN_REJ,
  output logic       FAULT,
  output logic [7:0] CREDIT,
  output logic       BUSY
);

  // Counter only needs to reach ACK_TIMEOUT-1: the timeout fires on that cycle.
  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    PAYOUT   = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] tmo_cnt_r;

  logic [7:0] coin_val_s;
  logic [8:0] coin_sum_s;
  logic       coin_present_s;
  logic       coin_fits_s;
  logic       sel_ok_s;

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 8'(PRICE0);
      2'd1:    price_of = 8'(PRICE1);
      2'd2:    price_of = 8'(PRICE2);
      2'd3:    price_of = 8'(PRICE3);
      default: price_of = 8'(PRICE3);
    endcase
  endfunction

  function automatic logic [7:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   coin_value = 8'd5;
      2'b10:   coin_value = 8'd10;
      default: coin_value = 8'd0;  // none or invalid code
    endcase
  endfunction

  // Coin and selection qualification; the sum is 9 bits so the ceiling test
  // cannot wrap.
  always_comb begin
    coin_val_s     = coin_value(COIN);
    coin_sum_s     = {1'b0, CREDIT} + {1'b0, coin_val_s};
    coin_present_s = (COIN != 2'b00);
    if (coin_val_s != 8'd0) begin
      coin_fits_s = (coin_sum_s <= 9'(MAX_CREDIT));
    end else begin
      coin_fits_s = 1'b0;
    end
    sel_ok_s = (CREDIT >= price_of(SEL));
  end

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      tmo_cnt_r    <= '0;
      DISP_REQ     <= 1'b0;
      DISP_SEL     <= 2'd0;
      CHANGE_PULSE <= 1'b0;
      COIN_REJ     <= 1'b0;
      FAULT        <= 1'b0;
      CREDIT       <= 8'd0;
      BUSY         <= 1'b0;
    end else begin
      COIN_REJ <= 1'b0;
      case (state_r)
        IDLE: begin
          // SEL_VALID and CANCEL carry no meaning without credit.
          if (coin_fits_s) begin
            CREDIT  <= coin_sum_s[7:0];
            state_r <= COLLECT;
          end else if (coin_present_s) begin
            COIN_REJ <= 1'b1;
          end
        end

        COLLECT: begin
          if (CANCEL) begin
            state_r      <= PAYOUT;
            BUSY         <= 1'b1;
            CHANGE_PULSE <= 1'b0;
            COIN_REJ     <= coin_present_s;
          end else if (SEL_VALID && sel_ok_s) begin
            DISP_SEL  <= SEL;
            CREDIT    <= CREDIT - price_of(SEL);
            DISP_REQ  <= 1'b1;
            BUSY      <= 1'b1;
            tmo_cnt_r <= '0;
            state_r   <= DISPENSE;
            COIN_REJ  <= coin_present_s;
          end else if (coin_fits_s) begin
            // An unaffordable selection falls through so the coin still counts.
            CREDIT <= coin_sum_s[7:0];
          end else if (coin_present_s) begin
            COIN_REJ <= 1'b1;
          end
        end

        DISPENSE: begin
          COIN_REJ <= coin_present_s;
          if (DISP_ACK) begin
            DISP_REQ <= 1'b0;
            if (CREDIT != 8'd0) begin
              state_r <= PAYOUT;
            end else begin
              state_r <= IDLE;
              BUSY    <= 1'b0;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            // Motor never answered: refund the full price along with any change.
            DISP_REQ <= 1'b0;
            FAULT    <= 1'b1;
            CREDIT   <= CREDIT + price_of(DISP_SEL);
            state_r  <= PAYOUT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
          end
        end

        PAYOUT: begin
          COIN_REJ <= coin_present_s;
          if (CHANGE_PULSE) begin
            // Low half of the pulse; leave once the last coin has gone out.
            CHANGE_PULSE <= 1'b0;
            if (CREDIT == 8'd0) begin
              state_r <= IDLE;
              BUSY    <= 1'b0;
            end
          end else if (CREDIT != 8'd0) begin
            CHANGE_PULSE <= 1'b1;
            CREDIT       <= CREDIT - 8'd5;
          end else begin
            state_r <= IDLE;
            BUSY    <= 1'b0;
          end
        end

        default: begin
          state_r      <= IDLE;
          DISP_REQ     <= 1'b0;
          CHANGE_PULSE <= 1'b0;
          BUSY         <= 1'b0;
          CREDIT       <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
`timescale 1ns/1ps
// tb_vend_sequencer
// Directed self-checking bench for vend_sequencer. Inputs change 1ns after a
// rising edge and outputs are sampled at that same point, so each cyc() call
// shows the registered response to the inputs it applied.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] COIN;
  logic       SEL_VALID;
  logic [1:0] SEL;
  logic       CANCEL;
  logic       DISP_ACK;
  logic       DISP_REQ;
  logic [1:0] DISP_SEL;
  logic       CHANGE_PULSE;
  logic       COIN_REJ;
  logic       FAULT;
  logic [7:0] CREDIT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_sequencer dut (
    .clk(clk), .reset(reset), .COIN(COIN), .SEL_VALID(SEL_VALID), .SEL(SEL),
    .CANCEL(CANCEL), .DISP_ACK(DISP_ACK), .DISP_REQ(DISP_REQ),
    .DISP_SEL(DISP_SEL), .CHANGE_PULSE(CHANGE_PULSE), .COIN_REJ(COIN_REJ),
    .FAULT(FAULT), .CREDIT(CREDIT), .BUSY(BUSY)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; strobes are cleared afterwards.
  task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] s,
                     input logic cn);
    COIN = c; SEL_VALID = sv; SEL = s; CANCEL = cn;
    @(posedge clk); #1;
    COIN = 2'b00; SEL_VALID = 1'b0; CANCEL = 1'b0;
  endtask

  task automatic idle();
    cyc(2'b00, 1'b0, 2'd0, 1'b0);
  endtask

  // Hold DISP_REQ checks for n cycles, then ack.
  task automatic ack_after(input string tag, input int n, input int sel);
    for (int i = 0; i < n; i++) begin
      idle();
      check({tag, "_req_hold"}, DISP_REQ, 1);
      check({tag, "_sel_hold"}, DISP_SEL, sel);
    end
    DISP_ACK = 1'b1;
    idle();
    DISP_ACK = 1'b0;
    check({tag, "_req_drop"}, DISP_REQ, 0);
  endtask

  // Called just after the cycle that entered PAYOUT; counts change pulses
  // until BUSY falls.
  task automatic run_payout(input string tag, input int exp_pulses);
    int p = 0;
    int n = 0;
    int viol = 0;
    logic prev;
    check({tag, "_entry_busy"}, BUSY, 1);
    check({tag, "_entry_pulse"}, CHANGE_PULSE, 0);
    prev = CHANGE_PULSE;
    while (BUSY && n < 200) begin
      idle();
      n++;
      if (CHANGE_PULSE) p++;
      if (CHANGE_PULSE && prev) viol++;
      prev = CHANGE_PULSE;
    end
    check({tag, "_done_in_time"}, (n < 200) ? 1 : 0, 1);
    check({tag, "_pulses"}, p, exp_pulses);
    check({tag, "_alternate"}, viol, 0);
    check({tag, "_end_credit"}, CREDIT, 0);
    check({tag, "_end_pulse"}, CHANGE_PULSE, 0);
  endtask

  initial begin
    int hi;
    int n;
    COIN = 2'b00; SEL_VALID = 1'b0; SEL = 2'd0; CANCEL = 1'b0; DISP_ACK = 1'b0;
    reset = 1'b0;
    idle(); idle();
    reset = 1'b1;
    check("rst_credit", CREDIT, 0);
    check("rst_req", DISP_REQ, 0);
    check("rst_busy", BUSY, 0);
    check("rst_fault", FAULT, 0);
    check("rst_pulse", CHANGE_PULSE, 0);
    check("rst_rej", COIN_REJ, 0);

    // 1: exact price, no change.
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    check("t1_c10", CREDIT, 10);
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    check("t1_c15", CREDIT, 15);
    cyc(2'b00, 1'b1, 2'd0, 1'b0);
    check("t1_credit0", CREDIT, 0);
    check("t1_req", DISP_REQ, 1);
    check("t1_sel", DISP_SEL, 0);
    check("t1_busy", BUSY, 1);
    ack_after("t1", 2, 0);
    check("t1_idle_busy", BUSY, 0);
    check("t1_no_pulse", CHANGE_PULSE, 0);
    idle();
    check("t1_no_pulse2", CHANGE_PULSE, 0);

    // 2: 30 credit, product 1 (20), Rs10 change.
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    check("t2_c30", CREDIT, 30);
    cyc(2'b00, 1'b1, 2'd1, 1'b0);
    check("t2_c10", CREDIT, 10);
    check("t2_sel", DISP_SEL, 1);
    ack_after("t2", 1, 1);
    check("t2_credit_after_ack", CREDIT, 10);
    run_payout("t2", 2);

    // 3: credit ceiling, then cancel.
    for (int i = 0; i < 10; i++) cyc(2'b01, 1'b0, 2'd0, 1'b0);
    check("t3_c50", CREDIT, 50);
    check("t3_no_rej", COIN_REJ, 0);
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    check("t3_rej", COIN_REJ, 1);
    check("t3_c50_hold", CREDIT, 50);
    cyc(2'b00, 1'b0, 2'd0, 1'b1);
    check("t3_rej_clear", COIN_REJ, 0);
    run_payout("t3", 10);

    // 4: unaffordable selection ignored; cancel with same-cycle coin.
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b1, 2'd3, 1'b0);
    check("t4_c10", CREDIT, 10);
    check("t4_no_req", DISP_REQ, 0);
    check("t4_not_busy", BUSY, 0);
    cyc(2'b01, 1'b0, 2'd0, 1'b1);
    check("t4_rej", COIN_REJ, 1);
    check("t4_credit", CREDIT, 10);
    run_payout("t4", 2);

    // 5: motor timeout. Product 2 (25) is unaffordable at 20, so product 1
    // (20) is dispensed to get the refund of 20 the scenario expects.
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b1, 2'd2, 1'b0);
    check("t5_sel2_ignored", DISP_REQ, 0);
    check("t5_c20", CREDIT, 20);
    cyc(2'b00, 1'b1, 2'd1, 1'b0);
    check("t5_req", DISP_REQ, 1);
    hi = 1;
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    check("t5_disp_coin_rej", COIN_REJ, 1);
    check("t5_disp_credit", CREDIT, 0);
    if (DISP_REQ) hi++;
    n = 0;
    while (DISP_REQ && n < 40) begin
      idle();
      n++;
      if (DISP_REQ) hi++;
    end
    check("t5_req_cycles", hi, 16);
    check("t5_fault", FAULT, 1);
    check("t5_refund", CREDIT, 20);
    run_payout("t5", 4);
    check("t5_fault_sticky", FAULT, 1);

    // 6: reset mid-dispense.
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b1, 2'd0, 1'b0);
    idle();
    check("t6_req_before", DISP_REQ, 1);
    reset = 1'b0;
    idle();
    reset = 1'b1;
    check("t6_req", DISP_REQ, 0);
    check("t6_credit", CREDIT, 0);
    check("t6_busy", BUSY, 0);
    check("t6_fault", FAULT, 0);
    check("t6_sel", DISP_SEL, 0);
    check("t6_pulse", CHANGE_PULSE, 0);
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    check("t6_c5", CREDIT, 5);
    check("t6_no_rej", COIN_REJ, 0);
    cyc(2'b11, 1'b0, 2'd0, 1'b0);
    check("t6_invalid_rej", COIN_REJ, 1);
    check("t6_c5_hold", CREDIT, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
